se: RTL and testbench



---
 rtl/se.sv | 47 ++++
 tb/tb_se.sv | 136 +++++++++++++
 2 files changed

// File: rtl/se.sv
// Immediate sign-extension unit: decodes the I/S/B/J immediate of an RV32I
// instruction, sign-extends it to 32 bits and registers the result.
module se (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [1:0]  src,
    output logic [31:0] immExt
);

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } immFormat_t;

    logic [31:0] w_immDecoded;
    logic [31:0] r_immExt;
    logic        w_signBit;

    assign w_signBit = instr[31];

    // B and J immediates encode halfword offsets, so bit 0 is always zero.
    always_comb begin
        w_immDecoded = 32'h0000_0000;
        case (immFormat_t'(src))
            FMT_I: w_immDecoded = {{20{w_signBit}}, instr[31:20]};
            FMT_S: w_immDecoded = {{20{w_signBit}}, instr[31:25], instr[11:7]};
            FMT_B: w_immDecoded = {{19{w_signBit}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0};
            FMT_J: w_immDecoded = {{11{w_signBit}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_immExt <= 32'h0000_0000;
        end else begin
            r_immExt <= w_immDecoded;
        end
    end

    assign immExt = r_immExt;

endmodule

// File: tb/tb_se.sv
// Self-checking bench for the immediate sign-extension unit: a table of
// directed vectors plus hand-written reset, latency and hold sequences.
module tb_se;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [1:0]  src;
    logic [31:0] immExt;

    int testsRun;
    int testsFailed;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [1:0]  src;
        logic [31:0] expected;
    } vector_t;

    vector_t vectors[16];

    se dut (
        .clk    (clk),
        .rst    (rst),
        .instr  (instr),
        .src    (src),
        .immExt (immExt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so they are stable at the next rising edge.
    task automatic applyStimulus(input logic [31:0] newInstr, input logic [1:0] newSrc,
                                 input logic newRst);
        @(negedge clk);
        instr = newInstr;
        src   = newSrc;
        rst   = newRst;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expected);
        testsRun++;
        if (immExt !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, immExt, expected);
        end
    endtask

    // Drive one vector, let one rising edge pass, then sample 1 time unit later.
    task automatic runVector(input string name, input logic [31:0] newInstr,
                             input logic [1:0] newSrc, input logic [31:0] expected);
        applyStimulus(newInstr, newSrc, 1'b0);
        @(posedge clk);
        #1;
        checkOutput(name, expected);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        vectors[0]  = '{"I neg",        32'hA750_0000, 2'b00, 32'hFFFF_FA75};
        vectors[1]  = '{"I pos",        32'h0010_0000, 2'b00, 32'h0000_0001};
        vectors[2]  = '{"S neg",        32'hA600_0A80, 2'b01, 32'hFFFF_FA75};
        vectors[3]  = '{"B neg",        32'hA600_0A80, 2'b10, 32'hFFFF_FA74};
        vectors[4]  = '{"B pos",        32'h2600_0A80, 2'b10, 32'h0000_0A74};
        vectors[5]  = '{"J neg",        32'hA600_0A80, 2'b11, 32'hFFF0_0260};
        vectors[6]  = '{"J pos",        32'h2600_0A80, 2'b11, 32'h0000_0260};
        vectors[7]  = '{"I ones",       32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF};
        vectors[8]  = '{"S ones",       32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFF};
        vectors[9]  = '{"B ones",       32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFE};
        vectors[10] = '{"J ones",       32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE};
        vectors[11] = '{"I max pos",    32'h7FFF_FFFF, 2'b00, 32'h0000_07FF};
        vectors[12] = '{"S max pos",    32'h7FFF_FFFF, 2'b01, 32'h0000_07FF};
        vectors[13] = '{"B max pos",    32'h7FFF_FFFF, 2'b10, 32'h0000_0FFE};
        vectors[14] = '{"J max pos",    32'h7FFF_FFFF, 2'b11, 32'h000F_FFFE};
        vectors[15] = '{"I ignores low",32'h000F_FFFF, 2'b00, 32'h0000_0000};

        instr = 32'h0;
        src   = 2'b00;
        rst   = 1'b1;

        // Reset held for two edges with non-zero inputs.
        applyStimulus(32'hA750_0000, 2'b00, 1'b1);
        @(posedge clk); #1;
        checkOutput("reset edge 1", 32'h0000_0000);
        applyStimulus(32'hFFFF_FFFF, 2'b11, 1'b1);
        @(posedge clk); #1;
        checkOutput("reset edge 2", 32'h0000_0000);

        runVector("reset release", 32'hA750_0000, 2'b00, 32'hFFFF_FA75);

        foreach (vectors[i]) begin
            runVector(vectors[i].name, vectors[i].instr, vectors[i].src, vectors[i].expected);
        end

        // Format change alone with the instruction held constant.
        runVector("src S", 32'hA600_0A80, 2'b01, 32'hFFFF_FA75);
        runVector("src B", 32'hA600_0A80, 2'b10, 32'hFFFF_FA74);
        runVector("src J", 32'hA600_0A80, 2'b11, 32'hFFF0_0260);

        // Hold between edges: output keeps the J value until the next edge.
        applyStimulus(32'hA750_0000, 2'b00, 1'b0);
        #1;
        checkOutput("hold after input change", 32'hFFF0_0260);
        @(posedge clk); #1;
        checkOutput("update after edge", 32'hFFFF_FA75);

        // Reset mid-stream while inputs toggle.
        applyStimulus(32'h0010_0000, 2'b00, 1'b1);
        @(posedge clk); #1;
        checkOutput("mid reset 1", 32'h0000_0000);
        applyStimulus(32'hFFFF_FFFF, 2'b10, 1'b1);
        @(posedge clk); #1;
        checkOutput("mid reset 2", 32'h0000_0000);
        applyStimulus(32'hA600_0A80, 2'b01, 1'b1);
        #1;
        checkOutput("mid reset hold", 32'h0000_0000);
        @(posedge clk); #1;
        checkOutput("mid reset 3", 32'h0000_0000);

        runVector("fresh after reset", 32'hA600_0A80, 2'b11, 32'hFFF0_0260);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
